// File: rtl/data_memory_arbiter_pkg.sv
// Shared encodings for the two-port data memory arbiter: FSM states and port indices.
package data_memory_arbiter_pkg;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_ISSUE = 2'd1;
    localparam logic [1:0] STATE_WAIT  = 2'd2;
    localparam logic [1:0] STATE_RESP  = 2'd3;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// Two-requester winner select: fixed priority (port 0 first) or round-robin
// keyed on the last-served port. Purely combinational.
module rr_arbiter2
    import data_memory_arbiter_pkg::*;
(
    input  logic input_req0,
    input  logic input_req1,
    input  logic input_last_served,
    input  logic input_fixed_priority,
    output logic output_winner
);

    always_comb begin
        output_winner = PORT0;
        if (input_fixed_priority) begin
            output_winner = input_req0 ? PORT0 : PORT1;
        end else if (input_req0 && input_req1) begin
            // On a tie the port that was not served last goes next.
            output_winner = (input_last_served == PORT0) ? PORT1 : PORT0;
        end else if (input_req1) begin
            output_winner = PORT1;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbitrates two request ports onto one external data memory with a fixed
// IDLE -> ISSUE -> WAIT -> RESP sequence per transaction.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY    = 1,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic       input_clk,
    input  logic       input_reset,
    input  logic       input_Req0,
    input  logic       input_Req1,
    input  logic       input_We0,
    input  logic       input_We1,
    input  logic [7:0] input_Addr0,
    input  logic [7:0] input_Addr1,
    input  logic [7:0] input_Wdata0,
    input  logic [7:0] input_Wdata1,
    output logic       output_Ack0,
    output logic       output_Ack1,
    output logic [7:0] output_Rdata0,
    output logic [7:0] output_Rdata1,
    output logic [7:0] output_Address,
    output logic [7:0] output_Writedata,
    output logic       output_Memread,
    output logic       output_Memwrite,
    input  logic [7:0] input_Readdata,
    output logic [1:0] output_state
);

    localparam logic [3:0] LATENCY_LOAD = 4'(MEM_LATENCY);
    localparam logic       FIXED_BIT    = (FIXED_PRIORITY != 0);

    logic [1:0] state;
    logic       last_served;
    logic       port_q;
    logic       we_q;
    logic [3:0] wait_cnt;
    logic       winner;
    logic       sel_we;
    logic [7:0] sel_addr;
    logic [7:0] sel_wdata;

    assign output_state = state;

    rr_arbiter2 u_rr_arbiter2 (
        .input_req0           (input_Req0),
        .input_req1           (input_Req1),
        .input_last_served    (last_served),
        .input_fixed_priority (FIXED_BIT),
        .output_winner        (winner)
    );

    always_comb begin
        sel_we    = input_We0;
        sel_addr  = input_Addr0;
        sel_wdata = input_Wdata0;
        if (winner == PORT1) begin
            sel_we    = input_We1;
            sel_addr  = input_Addr1;
            sel_wdata = input_Wdata1;
        end
    end

    // Handshake: a requester raises Req with We/Addr/Wdata stable and holds them
    // until its one-cycle Ack; only the values sampled in IDLE are used, and a
    // Req still high during RESP counts as a fresh request at the next IDLE edge.
    always_ff @(posedge input_clk or posedge input_reset) begin
        if (input_reset) begin
            state            <= STATE_IDLE;
            last_served      <= PORT1;
            port_q           <= PORT0;
            we_q             <= 1'b0;
            wait_cnt         <= 4'd0;
            output_Ack0      <= 1'b0;
            output_Ack1      <= 1'b0;
            output_Rdata0    <= 8'h00;
            output_Rdata1    <= 8'h00;
            output_Address   <= 8'h00;
            output_Writedata <= 8'h00;
            output_Memread   <= 1'b0;
            output_Memwrite  <= 1'b0;
        end else begin
            output_Memread  <= 1'b0;
            output_Memwrite <= 1'b0;
            output_Ack0     <= 1'b0;
            output_Ack1     <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (input_Req0 || input_Req1) begin
                        port_q           <= winner;
                        last_served      <= winner;
                        we_q             <= sel_we;
                        output_Address   <= sel_addr;
                        output_Writedata <= sel_wdata;
                        output_Memwrite  <= sel_we;
                        output_Memread   <= !sel_we;
                        state            <= STATE_ISSUE;
                    end
                end
                STATE_ISSUE: begin
                    wait_cnt <= LATENCY_LOAD;
                    state    <= STATE_WAIT;
                end
                STATE_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= STATE_RESP;
                        if (port_q == PORT1) begin
                            output_Ack1 <= 1'b1;
                            if (!we_q) output_Rdata1 <= input_Readdata;
                        end else begin
                            output_Ack0 <= 1'b1;
                            if (!we_q) output_Rdata0 <= input_Readdata;
                        end
                    end
                end
                default: begin
                    state <= STATE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: default, fixed-priority and
// MEM_LATENCY=3 instances, with a small memory model behind the default one.
module tb_data_memory_arbiter;
    import data_memory_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [0:0] exp_q[$];

    // default instance (round-robin, latency 1)
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, memread, memwrite;
    logic [7:0] rdata0, rdata1, address, writedata, readdata;
    logic [1:0] dbg_state;
    logic [7:0] mem [256];

    // fixed-priority instance
    logic       fp_req0, fp_req1, fp_we0, fp_we1;
    logic [7:0] fp_addr0, fp_addr1, fp_wdata0, fp_wdata1, fp_readdata;
    logic       fp_ack0, fp_ack1, fp_memread, fp_memwrite;
    logic [7:0] fp_rdata0, fp_rdata1, fp_address, fp_writedata;
    logic [1:0] fp_state;

    // latency-3 instance
    logic       l3_req0, l3_req1, l3_we0, l3_we1;
    logic [7:0] l3_addr0, l3_addr1, l3_wdata0, l3_wdata1, l3_readdata;
    logic       l3_ack0, l3_ack1, l3_memread, l3_memwrite;
    logic [7:0] l3_rdata0, l3_rdata1, l3_address, l3_writedata;
    logic [1:0] l3_state;

    assign readdata = mem[address];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else if (memwrite) begin
            mem[address] <= writedata;
        end
    end

    data_memory_arbiter #(.MEM_LATENCY(1), .FIXED_PRIORITY(0)) u_dut (
        .input_clk(clk), .input_reset(rst),
        .input_Req0(req0), .input_Req1(req1), .input_We0(we0), .input_We1(we1),
        .input_Addr0(addr0), .input_Addr1(addr1), .input_Wdata0(wdata0), .input_Wdata1(wdata1),
        .output_Ack0(ack0), .output_Ack1(ack1), .output_Rdata0(rdata0), .output_Rdata1(rdata1),
        .output_Address(address), .output_Writedata(writedata),
        .output_Memread(memread), .output_Memwrite(memwrite),
        .input_Readdata(readdata), .output_state(dbg_state)
    );

    data_memory_arbiter #(.MEM_LATENCY(1), .FIXED_PRIORITY(1)) u_dut_fp (
        .input_clk(clk), .input_reset(rst),
        .input_Req0(fp_req0), .input_Req1(fp_req1), .input_We0(fp_we0), .input_We1(fp_we1),
        .input_Addr0(fp_addr0), .input_Addr1(fp_addr1), .input_Wdata0(fp_wdata0), .input_Wdata1(fp_wdata1),
        .output_Ack0(fp_ack0), .output_Ack1(fp_ack1), .output_Rdata0(fp_rdata0), .output_Rdata1(fp_rdata1),
        .output_Address(fp_address), .output_Writedata(fp_writedata),
        .output_Memread(fp_memread), .output_Memwrite(fp_memwrite),
        .input_Readdata(fp_readdata), .output_state(fp_state)
    );

    data_memory_arbiter #(.MEM_LATENCY(3), .FIXED_PRIORITY(0)) u_dut_l3 (
        .input_clk(clk), .input_reset(rst),
        .input_Req0(l3_req0), .input_Req1(l3_req1), .input_We0(l3_we0), .input_We1(l3_we1),
        .input_Addr0(l3_addr0), .input_Addr1(l3_addr1), .input_Wdata0(l3_wdata0), .input_Wdata1(l3_wdata1),
        .output_Ack0(l3_ack0), .output_Ack1(l3_ack1), .output_Rdata0(l3_rdata0), .output_Rdata1(l3_rdata1),
        .output_Address(l3_address), .output_Writedata(l3_writedata),
        .output_Memread(l3_memread), .output_Memwrite(l3_memwrite),
        .input_Readdata(l3_readdata), .output_state(l3_state)
    );

    task automatic idle_all;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        fp_req0 = 0; fp_req1 = 0; fp_we0 = 0; fp_we1 = 0; fp_addr0 = 0; fp_addr1 = 0;
        fp_wdata0 = 0; fp_wdata1 = 0; fp_readdata = 0;
        l3_req0 = 0; l3_req1 = 0; l3_we0 = 0; l3_we1 = 0; l3_addr0 = 0; l3_addr1 = 0;
        l3_wdata0 = 0; l3_wdata1 = 0; l3_readdata = 0;
    endtask

    task automatic do_reset;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
    endtask

    task automatic test_reset;
        #12;
        n_total++;
        if ({ack0, ack1, memread, memwrite} !== 4'b0000 || rdata0 !== 8'h00 || rdata1 !== 8'h00 ||
            address !== 8'h00 || writedata !== 8'h00 || dbg_state !== STATE_IDLE) begin
            n_bad++;
            $display("FAIL reset_outputs: ack=%b%b rd=%b wr=%b rdata=%h/%h addr=%h wdata=%h state=%0d, required all zero, IDLE",
                     ack0, ack1, memread, memwrite, rdata0, rdata1, address, writedata, dbg_state);
        end
        n_total++;
        if (fp_state !== STATE_IDLE || l3_state !== STATE_IDLE || fp_memread !== 1'b0 || l3_memread !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_other_instances: fp_state=%0d l3_state=%0d, required 0 0", fp_state, l3_state);
        end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_single_read;
        @(negedge clk); req0 = 1; we0 = 0; addr0 = 8'h05;
        @(negedge clk);
        n_total++;
        if (memread !== 1'b1 || memwrite !== 1'b0 || address !== 8'h05 || dbg_state !== STATE_ISSUE) begin
            n_bad++;
            $display("FAIL single_read_issue: rd=%b wr=%b addr=%h state=%0d, required 1 0 05 1", memread, memwrite, address, dbg_state);
        end
        @(negedge clk);
        n_total++;
        if (memread !== 1'b0 || address !== 8'h05 || dbg_state !== STATE_WAIT || ack0 !== 1'b0) begin
            n_bad++;
            $display("FAIL single_read_wait: rd=%b addr=%h state=%0d ack0=%b, required 0 05 2 0", memread, address, dbg_state, ack0);
        end
        @(negedge clk);
        n_total++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || rdata0 !== 8'h05) begin
            n_bad++;
            $display("FAIL single_read_resp: ack0=%b ack1=%b rdata0=%h, required 1 0 05", ack0, ack1, rdata0);
        end
        req0 = 0;
        @(negedge clk);
        n_total++;
        if (ack0 !== 1'b0 || dbg_state !== STATE_IDLE || rdata0 !== 8'h05) begin
            n_bad++;
            $display("FAIL single_read_after: ack0=%b state=%0d rdata0=%h, required 0 0 05", ack0, dbg_state, rdata0);
        end
    endtask

    task automatic test_write_read;
        int pulses;
        int reads;
        bit got;
        @(negedge clk); req1 = 1; we1 = 1; addr1 = 8'h10; wdata1 = 8'hA5;
        pulses = 0; reads = 0; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (memread === 1'b1) reads++;
            if (memwrite === 1'b1) begin
                pulses++;
                n_total++;
                if (address !== 8'h10 || writedata !== 8'hA5) begin
                    n_bad++;
                    $display("FAIL write_strobe_data: addr=%h wdata=%h, required 10 A5", address, writedata);
                end
            end
            if (ack1 === 1'b1) begin got = 1; req1 = 0; end
        end
        n_total++;
        if (!got || pulses != 1 || reads != 0) begin
            n_bad++;
            $display("FAIL write_handshake: acked=%0d memwrite_pulses=%0d memread_pulses=%0d, required 1 1 0", got, pulses, reads);
        end
        n_total++;
        if (rdata1 !== 8'h00 || rdata0 !== 8'h05) begin
            n_bad++;
            $display("FAIL write_keeps_rdata: rdata0=%h rdata1=%h, required 05 00", rdata0, rdata1);
        end
        @(negedge clk); req1 = 1; we1 = 0; addr1 = 8'h10;
        got = 0; reads = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (memread === 1'b1) reads++;
            if (ack1 === 1'b1) begin got = 1; req1 = 0; end
        end
        n_total++;
        if (!got || reads != 1 || rdata1 !== 8'hA5 || rdata0 !== 8'h05) begin
            n_bad++;
            $display("FAIL read_back: acked=%0d reads=%0d rdata1=%h rdata0=%h, required 1 1 A5 05", got, reads, rdata1, rdata0);
        end
    endtask

    task automatic test_round_robin;
        bit overlap;
        logic [0:0] exp_port;
        logic [7:0] got_data;
        do_reset();
        req0 = 1; we0 = 0; addr0 = 8'h20;
        req1 = 1; we1 = 0; addr1 = 8'h30;
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        overlap = 0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            if (ack0 === 1'b1 && ack1 === 1'b1) overlap = 1;
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                exp_port = exp_q.pop_front();
                got_data = ack1 ? rdata1 : rdata0;
                n_total++;
                if (ack1 !== exp_port || got_data !== (exp_port ? 8'h30 : 8'h20)) begin
                    n_bad++;
                    $display("FAIL rr_grant_order: granted port=%0d data=%h, required port=%0d data=%h",
                             ack1, got_data, exp_port, exp_port ? 8'h30 : 8'h20);
                end
                if (exp_q.size() == 0) begin req0 = 0; req1 = 0; end
            end
        end
        n_total++;
        if (exp_q.size() != 0 || overlap) begin
            n_bad++;
            $display("FAIL rr_completion: grants_missing=%0d simultaneous_acks=%0d, required 0 0", exp_q.size(), overlap);
            exp_q.delete();
            req0 = 0; req1 = 0;
        end
    endtask

    task automatic test_lost_request;
        bit saw;
        @(negedge clk); req0 = 1; we0 = 0; addr0 = 8'hFF;
        @(negedge clk); req1 = 1; we1 = 0; addr1 = 8'h33;
        @(negedge clk); req1 = 0;
        @(negedge clk);
        n_total++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || rdata0 !== 8'hFF) begin
            n_bad++;
            $display("FAIL top_address_read: ack0=%b ack1=%b rdata0=%h, required 1 0 FF", ack0, ack1, rdata0);
        end
        req0 = 0;
        saw = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack1 === 1'b1 || memread === 1'b1 || dbg_state !== STATE_IDLE) saw = 1;
        end
        n_total++;
        if (saw) begin
            n_bad++;
            $display("FAIL lost_request: activity after short pulse=%0d, required 0", saw);
        end
    endtask

    task automatic test_fixed_priority;
        bit saw1;
        bit got;
        int acks0;
        int wait_n;
        do_reset();
        fp_req0 = 1; fp_we0 = 0; fp_addr0 = 8'h01;
        fp_req1 = 1; fp_we1 = 0; fp_addr1 = 8'h02;
        saw1 = 0; acks0 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fp_ack1 === 1'b1) saw1 = 1;
            if (fp_ack0 === 1'b1) acks0++;
        end
        n_total++;
        if (saw1 || acks0 != 5) begin
            n_bad++;
            $display("FAIL fixed_priority_hold: port1_acked=%0d port0_acks=%0d, required 0 5", saw1, acks0);
        end
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (fp_ack0 === 1'b1) begin got = 1; fp_req0 = 0; end
        end
        wait_n = 0;
        saw1 = 0;
        for (int i = 0; i < 5 && !saw1; i++) begin
            @(negedge clk);
            wait_n++;
            if (fp_ack1 === 1'b1) begin saw1 = 1; fp_req1 = 0; end
        end
        n_total++;
        if (!got || !saw1) begin
            n_bad++;
            $display("FAIL fixed_priority_release: port0_ack_seen=%0d port1_ack_within_5=%0d after %0d cycles, required 1 1",
                     got, saw1, wait_n);
        end
        fp_req0 = 0; fp_req1 = 0;
    endtask

    task automatic test_latency3;
        do_reset();
        l3_req0 = 1; l3_we0 = 0; l3_addr0 = 8'h1F; l3_readdata = 8'h00;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) begin
                n_total++;
                if (l3_memread !== 1'b1 || l3_address !== 8'h1F || l3_ack0 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL l3_issue: rd=%b addr=%h ack0=%b, required 1 1F 0", l3_memread, l3_address, l3_ack0);
                end
            end else if (n <= 4) begin
                n_total++;
                if (l3_state !== STATE_WAIT || l3_ack0 !== 1'b0 || l3_memread !== 1'b0) begin
                    n_bad++;
                    $display("FAIL l3_wait_%0d: state=%0d ack0=%b rd=%b, required 2 0 0", n - 1, l3_state, l3_ack0, l3_memread);
                end
                case (n)
                    2: l3_readdata = 8'h11;
                    3: l3_readdata = 8'h22;
                    default: l3_readdata = 8'h3C;
                endcase
            end else if (n == 5) begin
                n_total++;
                if (l3_ack0 !== 1'b1 || l3_ack1 !== 1'b0 || l3_rdata0 !== 8'h3C) begin
                    n_bad++;
                    $display("FAIL l3_resp: ack0=%b ack1=%b rdata0=%h, required 1 0 3C", l3_ack0, l3_ack1, l3_rdata0);
                end
                l3_req0 = 0;
            end else begin
                n_total++;
                if (l3_ack0 !== 1'b0 || l3_state !== STATE_IDLE) begin
                    n_bad++;
                    $display("FAIL l3_after: ack0=%b state=%0d, required 0 0", l3_ack0, l3_state);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        bit saw;
        bit got;
        @(negedge clk); req0 = 1; we0 = 0; addr0 = 8'h40;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (dbg_state !== STATE_WAIT) begin
            n_bad++;
            $display("FAIL reset_mid_setup: state=%0d, required 2", dbg_state);
        end
        #2 rst = 1;
        #1;
        n_total++;
        if ({ack0, ack1, memread, memwrite} !== 4'b0000 || dbg_state !== STATE_IDLE || address !== 8'h00 || rdata0 !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid_immediate: ack=%b%b rd=%b wr=%b state=%0d addr=%h rdata0=%h, required zeros IDLE",
                     ack0, ack1, memread, memwrite, dbg_state, address, rdata0);
        end
        @(negedge clk); rst = 0; req0 = 0;
        saw = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack0 === 1'b1 || ack1 === 1'b1) saw = 1;
        end
        n_total++;
        if (saw) begin
            n_bad++;
            $display("FAIL reset_mid_no_ack: ack seen=%0d, required 0", saw);
        end
        req0 = 1; we0 = 0; addr0 = 8'h40;
        req1 = 1; we1 = 0; addr1 = 8'h50;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                got = 1;
                n_total++;
                if (ack0 !== 1'b1 || ack1 !== 1'b0 || rdata0 !== 8'h40) begin
                    n_bad++;
                    $display("FAIL reset_mid_first_tie: ack0=%b ack1=%b rdata0=%h, required 1 0 40", ack0, ack1, rdata0);
                end
                req0 = 0; req1 = 0;
            end
        end
        n_total++;
        if (!got) begin
            n_bad++;
            $display("FAIL reset_mid_timeout: no ack within 10 cycles, required one");
        end
        req0 = 0; req1 = 0;
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        idle_all();
        test_reset();
        test_single_read();
        test_write_read();
        test_round_robin();
        test_lost_request();
        test_fixed_priority();
        test_latency3();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
